// File: rtl/arbiter_rr_16_pkg.sv
// Shared constants, state encoding and the rotating priority search for arbiter_rr_16.
package arbiter_rr_16_pkg;

    localparam int ARB_N = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Result is {found, idx}; the requester at last_idx is searched last.
    function automatic logic [4:0] rr_pick(input logic [ARB_N-1:0] req, input logic [3:0] last_idx);
        logic [4:0] pick;
        logic [3:0] idx;
        pick = 5'd0;
        for (int k = ARB_N; k >= 1; k--) begin
            idx = last_idx + 4'(k);
            if (req[idx]) pick = {1'b1, idx};
        end
        return pick;
    endfunction

endpackage

// File: rtl/arbiter_rr_16_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface arbiter_rr_16_if;
    import arbiter_rr_16_pkg::*;

    logic [ARB_N-1:0] req;
    logic [ARB_N-1:0] gnt;
    logic [3:0]       gnt_idx;
    logic             gnt_valid;

    modport master (output req, input gnt, input gnt_idx, input gnt_valid);
    modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);
endinterface

// File: rtl/arbiter_rr_16_decoder_4x16.sv
// Index-to-one-hot decoder with enable; drives the resource selects directly.
module decoder_4x16 (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);
    always_comb begin
        onehot = 16'h0000;
        if (en) onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/arbiter_rr_16.sv
// Round-robin arbiter for 16 requesters with a bounded grant length and one
// dead cycle between consecutive grants.
module arbiter_rr_16
    import arbiter_rr_16_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    arbiter_rr_16_if.slave bus
);
    // state     | meaning
    // ARB_IDLE  | no grant; arbitrate among current requests
    // ARB_GRANT | gnt_idx owns the resource, hold_cnt counts its cycles

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t  state;
    logic [3:0]  gnt_idx;
    logic [3:0]  last_idx;
    logic [7:0]  hold_cnt;
    logic        gnt_valid;
    logic [4:0]  pick;
    logic [15:0] gnt_dec;

    assign pick = rr_pick(bus.req, last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            gnt_idx   <= 4'hF;
            last_idx  <= 4'hF;
            hold_cnt  <= 8'd0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick[4]) begin
                        gnt_idx   <= pick[3:0];
                        last_idx  <= pick[3:0];
                        hold_cnt  <= 8'd0;
                        gnt_valid <= 1'b1;
                        state     <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!bus.req[gnt_idx] || hold_cnt == HOLD_LAST) begin
                        gnt_valid <= 1'b0;
                        state     <= ARB_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    gnt_valid <= 1'b0;
                    state     <= ARB_IDLE;
                end
            endcase
        end
    end

    // gnt depends on registers only, so reset clears it without a clock edge.
    decoder_4x16 u_dec (
        .idx    (gnt_idx),
        .en     (gnt_valid),
        .onehot (gnt_dec)
    );

    assign bus.gnt       = gnt_dec;
    assign bus.gnt_idx   = gnt_idx;
    assign bus.gnt_valid = gnt_valid;

endmodule

// File: tb/tb_arbiter_rr_16.sv
// Directed bench for arbiter_rr_16 with MAX_HOLD of 1, 4 and 8.
module tb_arbiter_rr_16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errs = 0;
    int checks = 0;

    arbiter_rr_16_if bus1 ();
    arbiter_rr_16_if bus4 ();
    arbiter_rr_16_if bus8 ();

    arbiter_rr_16 #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    arbiter_rr_16 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    arbiter_rr_16 #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n    = 1'b0;
        bus1.req = 16'h0;
        bus4.req = 16'h0;
        bus8.req = 16'h0;
        #3;
        chk("rst_gnt", {bus1.gnt, bus8.gnt}, 32'h0);
        chk("rst_valid", {bus1.gnt_valid, bus4.gnt_valid, bus8.gnt_valid}, 32'h0);
        chk("rst_idx", {bus1.gnt_idx, bus4.gnt_idx, bus8.gnt_idx}, 32'hFFF);
        step();
        rst_n = 1'b1;
    endtask

    // MAX_HOLD=4 with req=8001, one entry per cycle after the first sampling edge
    logic [3:0] seq4_idx [11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
    logic       seq4_v   [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    logic [3:0] exp_idx;
    logic [15:0] exp_gnt;

    initial begin
        bus1.req = 16'h0;
        bus4.req = 16'h0;
        bus8.req = 16'h0;

        // idle with no requests
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_gnt", bus8.gnt, 32'h0);
            chk("idle_valid", bus8.gnt_valid, 32'h0);
            chk("idle_idx", bus8.gnt_idx, 32'hF);
        end

        // two requesters sharing, hold limit 4
        do_reset();
        bus4.req = 16'h8001;
        for (int i = 0; i < 11; i++) begin
            step();
            exp_gnt = seq4_v[i] ? (16'h1 << seq4_idx[i]) : 16'h0;
            chk($sformatf("hold4_gnt[%0d]", i), bus4.gnt, exp_gnt);
            chk($sformatf("hold4_valid[%0d]", i), bus4.gnt_valid, seq4_v[i]);
            chk($sformatf("hold4_idx[%0d]", i), bus4.gnt_idx, seq4_idx[i]);
        end

        // 15 -> 0 wrap
        do_reset();
        bus8.req = 16'h8000;
        step();
        chk("wrap_first", bus8.gnt, 32'h8000);
        bus8.req = 16'h0001;
        step();
        chk("wrap_release", bus8.gnt, 32'h0);
        step();
        chk("wrap_gnt", bus8.gnt, 32'h0001);
        chk("wrap_idx", bus8.gnt_idx, 32'h0);

        // short pulse on req[5]
        do_reset();
        bus8.req = 16'h0020;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 2) bus8.req = 16'h0;
            chk($sformatf("pulse_gnt[%0d]", i), bus8.gnt, (i < 3) ? 32'h0020 : 32'h0);
        end

        // all requests, hold limit 1: alternating grant/idle, period 32
        do_reset();
        bus1.req = 16'hFFFF;
        for (int s = 0; s < 34; s++) begin
            step();
            exp_idx = 4'((s / 2) % 16);
            exp_gnt = (s % 2 == 0) ? (16'h1 << exp_idx) : 16'h0;
            chk($sformatf("all_gnt[%0d]", s), bus1.gnt, exp_gnt);
            chk($sformatf("all_onehot[%0d]", s), ($countones(bus1.gnt) <= 1), 1);
        end

        // asynchronous reset in the middle of a grant
        do_reset();
        bus8.req = 16'h0100;
        step();
        chk("arst_pre", bus8.gnt, 32'h0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", bus8.gnt, 32'h0);
        chk("arst_idx", bus8.gnt_idx, 32'hF);
        #2;
        rst_n = 1'b1;
        step();
        chk("arst_regrant", bus8.gnt, 32'h0100);
        chk("arst_regrant_idx", bus8.gnt_idx, 32'h8);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
